// File: rtl/qspi_dma_engine_if.sv
`default_nettype none
// ============================================================================
// Module : qspi_dma_engine_if
// Brief  : AXI4 master channel bundle used by the QSPI DMA engine
// Rev    : 1.0
// ============================================================================
interface qspi_dma_engine_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [3:0]                  m_awid;
  logic [AXI_ADDR_WIDTH-1:0]   m_awaddr;
  logic [7:0]                  m_awlen;
  logic [2:0]                  m_awsize;
  logic [1:0]                  m_awburst;
  logic                        m_awvalid;
  logic                        m_awready;
  logic [DATA_WIDTH-1:0]       m_wdata;
  logic [DATA_WIDTH/8-1:0]     m_wstrb;
  logic                        m_wlast;
  logic                        m_wvalid;
  logic                        m_wready;
  logic [1:0]                  m_bresp;
  logic                        m_bvalid;
  logic                        m_bready;
  logic [3:0]                  m_arid;
  logic [AXI_ADDR_WIDTH-1:0]   m_araddr;
  logic [7:0]                  m_arlen;
  logic [2:0]                  m_arsize;
  logic [1:0]                  m_arburst;
  logic                        m_arvalid;
  logic                        m_arready;
  logic [DATA_WIDTH-1:0]       m_rdata;
  logic [1:0]                  m_rresp;
  logic                        m_rlast;
  logic                        m_rvalid;
  logic                        m_rready;

  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/qspi_dma_engine.sv
`default_nettype none
// ============================================================================
// Module : qspi_dma_engine
// Brief  : Single-channel AXI4 master DMA between QSPI RX/TX FIFOs and memory
// Rev    : 1.0
// ============================================================================
module qspi_dma_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BEATS      = 16,
  parameter int LVL_WIDTH      = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      dir_i,
  input  logic                      incr_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               len_i,
  input  logic [8:0]                burst_beats_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [31:0]               beats_done_o,
  input  logic [DATA_WIDTH-1:0]     rx_data_i,
  input  logic [LVL_WIDTH-1:0]      rx_level_i,
  output logic                      rx_ren_o,
  output logic [DATA_WIDTH-1:0]     tx_data_o,
  output logic                      tx_wen_o,
  input  logic [LVL_WIDTH-1:0]      tx_space_i,
  qspi_dma_engine_if.master         axi
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_AW_WAIT = 4'd1,
    S_AW      = 4'd2,
    S_W       = 4'd3,
    S_B       = 4'd4,
    S_AR_WAIT = 4'd5,
    S_AR      = 4'd6,
    S_R       = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t                    r_state, w_next;
  logic                      r_incr;
  logic [8:0]                r_cfg;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_rem;
  logic [31:0]               r_beats_done;
  logic [8:0]                r_blen;
  logic [8:0]                r_beat;
  logic                      r_err;
  logic                      r_abort;

  logic [8:0]  w_cfg_start;
  logic [31:0] w_page, w_min1, w_blen32;
  logic        w_abort, w_wlast, w_stop, w_bresp_err, w_rresp_err, w_len_zero;
  logic [7:0]  w_len_m1;

  always_comb begin
    w_cfg_start = (burst_beats_i == 9'd0) ? 9'd1 : burst_beats_i;
    if (32'(w_cfg_start) > MAX_BEATS) w_cfg_start = 9'(MAX_BEATS);
  end

  // FIXED bursts are capped at 16 beats; INCR bursts stop at the next 4KB page.
  always_comb begin
    w_page   = r_incr ? ((32'd4096 - 32'(r_addr[11:0])) >> LSB) : 32'd16;
    w_min1   = (32'(r_cfg) < r_rem) ? 32'(r_cfg) : r_rem;
    w_blen32 = (w_page < w_min1) ? w_page : w_min1;
  end

  assign w_abort     = r_abort | abort_i;
  assign w_wlast     = (r_beat == (r_blen - 9'd1));
  assign w_stop      = (r_rem == 32'(r_blen)) | r_err | w_abort;
  assign w_bresp_err = (axi.m_bresp != 2'b00);
  assign w_rresp_err = (axi.m_rresp != 2'b00);
  assign w_len_zero  = ((len_i >> LSB) == 32'd0);
  assign w_len_m1    = (r_blen == 9'd0) ? 8'd0 : 8'(r_blen - 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_next = w_len_zero ? S_DONE : (dir_i ? S_AR_WAIT : S_AW_WAIT);
      S_AW_WAIT: if (w_abort) w_next = S_DONE;
                 else if (32'(rx_level_i) >= w_blen32) w_next = S_AW;
      S_AW:      if (axi.m_awready) w_next = S_W;
      S_W:       if (axi.m_wready && w_wlast) w_next = S_B;
      S_B:       if (axi.m_bvalid) w_next = (w_stop | w_bresp_err) ? S_DONE : S_AW_WAIT;
      S_AR_WAIT: if (w_abort) w_next = S_DONE;
                 else if (32'(tx_space_i) >= w_blen32) w_next = S_AR;
      S_AR:      if (axi.m_arready) w_next = S_R;
      S_R:       if (axi.m_rvalid && axi.m_rlast) w_next = (w_stop | w_rresp_err) ? S_DONE : S_AR_WAIT;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_incr       <= 1'b0;
      r_cfg        <= 9'd0;
      r_addr       <= '0;
      r_rem        <= 32'd0;
      r_beats_done <= 32'd0;
      r_blen       <= 9'd0;
      r_beat       <= 9'd0;
      r_err        <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_incr       <= incr_i;
          r_cfg        <= w_cfg_start;
          r_addr       <= addr_i & ~AXI_ADDR_WIDTH'(BYTES - 1);
          r_rem        <= len_i >> LSB;
          r_beats_done <= 32'd0;
          r_err        <= 1'b0;
          r_abort      <= 1'b0;
        end
        // Burst length is frozen here so AxLEN and wlast stay stable for the burst.
        S_AW_WAIT, S_AR_WAIT: begin
          r_blen <= 9'(w_blen32);
          r_beat <= 9'd0;
        end
        S_W: if (axi.m_wready) r_beat <= r_beat + 9'd1;
        S_B: if (axi.m_bvalid) begin
          if (w_bresp_err) r_err <= 1'b1;
          r_addr       <= r_addr + (r_incr ? (AXI_ADDR_WIDTH'(r_blen) << LSB) : '0);
          r_rem        <= r_rem - 32'(r_blen);
          r_beats_done <= r_beats_done + 32'(r_blen);
        end
        S_R: if (axi.m_rvalid) begin
          if (w_rresp_err) r_err <= 1'b1;
          if (axi.m_rlast) begin
            r_addr       <= r_addr + (r_incr ? (AXI_ADDR_WIDTH'(r_blen) << LSB) : '0);
            r_rem        <= r_rem - 32'(r_blen);
            r_beats_done <= r_beats_done + 32'(r_blen);
          end
        end
        S_DONE:  r_abort <= 1'b0;
        default: ;
      endcase
      if (abort_i && (r_state != S_IDLE) && (r_state != S_DONE)) r_abort <= 1'b1;
    end
  end

  assign axi.m_awid    = 4'd0;
  assign axi.m_awaddr  = r_addr;
  assign axi.m_awlen   = w_len_m1;
  assign axi.m_awsize  = 3'(LSB);
  assign axi.m_awburst = r_incr ? 2'b01 : 2'b00;
  assign axi.m_awvalid = (r_state == S_AW);
  assign axi.m_wdata   = rx_data_i;
  assign axi.m_wstrb   = '1;
  assign axi.m_wvalid  = (r_state == S_W);
  assign axi.m_wlast   = (r_state == S_W) && w_wlast;
  assign axi.m_bready  = (r_state == S_B);
  assign axi.m_arid    = 4'd0;
  assign axi.m_araddr  = r_addr;
  assign axi.m_arlen   = w_len_m1;
  assign axi.m_arsize  = 3'(LSB);
  assign axi.m_arburst = r_incr ? 2'b01 : 2'b00;
  assign axi.m_arvalid = (r_state == S_AR);
  assign axi.m_rready  = (r_state == S_R);

  assign rx_ren_o     = (r_state == S_W) && axi.m_wready;
  assign tx_wen_o     = (r_state == S_R) && axi.m_rvalid;
  assign tx_data_o    = axi.m_rdata;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = r_err;
  assign beats_done_o = r_beats_done;
endmodule
`default_nettype wire

// File: tb/tb_qspi_dma_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_qspi_dma_engine
// Brief  : Directed bench: burst-plan model, AXI slave model and per-cycle compare
// Rev    : 1.0
// ============================================================================
module tb_qspi_dma_engine;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_i = 1'b0, dir_i = 1'b0, incr_i = 1'b1, abort_i = 1'b0;
  logic [31:0] addr_i = 32'd0, len_i = 32'd0;
  logic [8:0]  burst_beats_i = 9'd0;
  logic        busy_o, done_o, err_o, rx_ren_o, tx_wen_o;
  logic [31:0] beats_done_o, tx_data_o;
  logic [31:0] rx_data_i = 32'd0;
  logic [8:0]  rx_level_i = 9'd0, tx_space_i = 9'd256;

  qspi_dma_engine_if #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) axi ();

  qspi_dma_engine #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MAX_BEATS(16), .LVL_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .dir_i(dir_i), .incr_i(incr_i),
    .addr_i(addr_i), .len_i(len_i), .burst_beats_i(burst_beats_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .beats_done_o(beats_done_o),
    .rx_data_i(rx_data_i), .rx_level_i(rx_level_i), .rx_ren_o(rx_ren_o),
    .tx_data_o(tx_data_o), .tx_wen_o(tx_wen_o), .tx_space_i(tx_space_i), .axi(axi)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transfer model: the list of bursts and the read data the DMA must produce.
  logic [31:0] plan_addr[$];
  int          plan_len[$];
  logic [31:0] exp_tx[$];
  logic [31:0] obs_addr[$];
  int          obs_len[$];
  logic [31:0] wmem [logic [31:0]];
  bit          cfg_incr = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h5A000000 ^ (a * 32'd3);
  endfunction

  function automatic logic [31:0] rx_word(input int k);
    return 32'hC0DE0000 + 32'(k);
  endfunction

  task automatic build_plan(input bit incr, input logic [31:0] addr, input logic [31:0] len,
                            input int beats);
    logic [31:0] a;
    longint      rem;
    int          b, page, n;
    plan_addr.delete(); plan_len.delete(); exp_tx.delete();
    a   = addr & ~32'd3;
    rem = longint'(len / 4);
    b   = (beats == 0) ? 1 : ((beats > 16) ? 16 : beats);
    while (rem > 0) begin
      page = incr ? (4096 - int'(a[11:0])) / 4 : 16;
      n = b;
      if (rem < longint'(n)) n = int'(rem);
      if (page < n) n = page;
      plan_addr.push_back(a);
      plan_len.push_back(n);
      for (int i = 0; i < n; i++) exp_tx.push_back(mem_word(a + (incr ? 32'(i * 4) : 32'd0)));
      if (incr) a = a + 32'(n * 4);
      rem -= n;
    end
  endtask

  // Slave / FIFO state, owned by the bus process.
  int          bursts_seen = 0, wbeats_seen = 0, rx_ptr = 0, rx_avail = 0;
  int          rbeat_glob = 0, err_rbeat = -1, done_cnt = 0;
  int          s_len = 0, s_beat = 0, b_wait = 0;
  logic [31:0] s_addr = 32'd0;
  bit          b_pend = 1'b0, r_act = 1'b0;

  initial begin
    axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
    axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rdata = 32'd0; axi.m_rresp = 2'b00;
    axi.m_rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0;
        axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rlast = 1'b0;
        b_pend = 1'b0; r_act = 1'b0;
        continue;
      end
      axi.m_awready = ($urandom_range(0, 3) != 0);
      axi.m_wready  = ($urandom_range(0, 3) != 0);
      axi.m_arready = ($urandom_range(0, 2) != 0);
      if (b_pend && b_wait > 0) b_wait--;
      axi.m_bvalid  = b_pend && (b_wait == 0);
      axi.m_bresp   = 2'b00;
      axi.m_rvalid  = r_act && ($urandom_range(0, 3) != 0);
      axi.m_rdata   = mem_word(s_addr + (cfg_incr ? 32'(s_beat * 4) : 32'd0));
      axi.m_rlast   = r_act && (s_beat == s_len - 1);
      axi.m_rresp   = (rbeat_glob == err_rbeat) ? 2'b10 : 2'b00;
      rx_data_i     = rx_word(rx_ptr);
      rx_level_i    = 9'(rx_avail);
      #4;
      if (!rst_n) continue;
      chk("rx_ren_vs_w_handshake", rx_ren_o, axi.m_wvalid & axi.m_wready);
      chk("tx_wen_vs_r_handshake", tx_wen_o, axi.m_rvalid & axi.m_rready);
      if (axi.m_awvalid && bursts_seen < plan_len.size())
        chk("aw_rx_level_gate", int'(rx_level_i) >= plan_len[bursts_seen], 1'b1);
      if (axi.m_arvalid && bursts_seen < plan_len.size())
        chk("ar_tx_space_gate", int'(tx_space_i) >= plan_len[bursts_seen], 1'b1);
      if ((axi.m_awvalid && axi.m_awready) || (axi.m_arvalid && axi.m_arready)) begin
        logic [31:0] ad;
        logic [7:0]  ln;
        logic [1:0]  bt;
        logic [2:0]  sz;
        ad = axi.m_awvalid ? axi.m_awaddr  : axi.m_araddr;
        ln = axi.m_awvalid ? axi.m_awlen   : axi.m_arlen;
        bt = axi.m_awvalid ? axi.m_awburst : axi.m_arburst;
        sz = axi.m_awvalid ? axi.m_awsize  : axi.m_arsize;
        if (bursts_seen < plan_len.size()) begin
          chk("burst_addr", ad, plan_addr[bursts_seen]);
          chk("burst_len", ln, 8'(plan_len[bursts_seen] - 1));
        end else begin
          chk("extra_burst_issued", 1'b1, 1'b0);
        end
        chk("burst_type", bt, cfg_incr ? 2'b01 : 2'b00);
        chk("burst_size", sz, 3'd2);
        obs_addr.push_back(ad);
        obs_len.push_back(int'(ln) + 1);
        s_addr = ad; s_len = int'(ln) + 1; s_beat = 0;
        r_act  = axi.m_arvalid;
        bursts_seen++;
      end
      if (axi.m_wvalid && axi.m_wready) begin
        chk("w_data", axi.m_wdata, rx_word(wbeats_seen));
        chk("w_last", axi.m_wlast, s_beat == s_len - 1);
        chk("w_strb", axi.m_wstrb, 4'hF);
        wmem[s_addr + (cfg_incr ? 32'(s_beat * 4) : 32'd0)] = axi.m_wdata;
        s_beat++;
        wbeats_seen++;
        if (s_beat == s_len) begin b_pend = 1'b1; b_wait = $urandom_range(0, 2); end
      end
      if (rx_ren_o) begin rx_ptr++; rx_avail--; end
      if (axi.m_bvalid && axi.m_bready) b_pend = 1'b0;
      if (tx_wen_o) begin
        if (rbeat_glob < exp_tx.size()) chk("tx_data", tx_data_o, exp_tx[rbeat_glob]);
        else chk("tx_beat_beyond_plan", 1'b1, 1'b0);
        chk("r_last", axi.m_rlast, s_beat == s_len - 1);
        s_beat++;
        rbeat_glob++;
        if (s_beat == s_len) r_act = 1'b0;
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic check_reset_outs(input string name);
    chk(name, {busy_o, done_o, err_o, rx_ren_o, tx_wen_o, axi.m_awvalid, axi.m_wvalid,
               axi.m_wlast, axi.m_bready, axi.m_arvalid, axi.m_rready}, 11'd0);
    chk({name, "_beats"}, beats_done_o, 32'd0);
  endtask

  task automatic start_xfer(input bit dir, input bit incr, input logic [31:0] addr,
                            input logic [31:0] len, input int beats);
    build_plan(incr, addr, len, beats);
    cfg_incr = incr; bursts_seen = 0; rbeat_glob = 0; done_cnt = 0;
    obs_addr.delete(); obs_len.delete();
    @(negedge clk);
    dir_i = dir; incr_i = incr; addr_i = addr; len_i = len; burst_beats_i = 9'(beats);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin @(negedge clk); n++; end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done_o after %0d cycles, expected one pulse", name, n);
    end
    chk({name, "_busy_after_done"}, busy_o, 1'b0);
    repeat (3) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    #1 check_reset_outs("reset_outputs");
    rst_n = 1'b1;

    // T1: RX->memory, four 4-beat bursts
    rx_avail = 64; base = wbeats_seen;
    start_xfer(1'b0, 1'b1, 32'h1000, 32'd64, 4);
    wait_done("t1");
    chk("t1_plan_bursts", plan_len.size(), 4);
    chk("t1_bursts", bursts_seen, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_addr.size()) begin
        chk("t1_awaddr", obs_addr[i], 32'h1000 + 32'(16 * i));
        chk("t1_awlen", obs_len[i], 4);
      end
    end
    chk("t1_beats_done", beats_done_o, 32'd16);
    chk("t1_err", err_o, 1'b0);
    chk("t1_rx_pops", wbeats_seen - base, 16);
    chk("t1_mem_last_word", wmem[32'h1030], rx_word(base + 12));

    // T2: memory->TX with a 4KB split
    start_xfer(1'b1, 1'b1, 32'h0FF8, 32'd32, 16);
    wait_done("t2");
    chk("t2_plan_first_len", plan_len[0], 2);
    chk("t2_bursts", bursts_seen, 2);
    if (obs_addr.size() == 2) begin
      chk("t2_araddr0", obs_addr[0], 32'h0FF8);
      chk("t2_arlen0", obs_len[0], 2);
      chk("t2_araddr1", obs_addr[1], 32'h1000);
      chk("t2_arlen1", obs_len[1], 6);
    end
    chk("t2_tx_beats", rbeat_glob, 8);
    chk("t2_beats_done", beats_done_o, 32'd8);

    // T3: FIFO-level gating and a partial burst
    rx_avail = 3;
    start_xfer(1'b0, 1'b1, 32'h2000, 32'd40, 16);
    repeat (10) @(negedge clk);
    chk("t3_no_aw_while_low", bursts_seen, 0);
    rx_avail = 10;
    wait_done("t3");
    chk("t3_bursts", bursts_seen, 1);
    if (obs_len.size() > 0) chk("t3_awlen", obs_len[0], 10);
    chk("t3_beats_done", beats_done_o, 32'd10);

    // T4: read error on beat 2 of the first of three bursts
    err_rbeat = 1;
    start_xfer(1'b1, 1'b1, 32'h3000, 32'd48, 4);
    wait_done("t4");
    chk("t4_bursts", bursts_seen, 1);
    chk("t4_rbeats", rbeat_glob, 4);
    chk("t4_err", err_o, 1'b1);
    chk("t4_beats_done", beats_done_o, 32'd4);
    err_rbeat = -1;
    start_xfer(1'b1, 1'b1, 32'h3100, 32'd16, 4);
    chk("t4_err_cleared_on_start", err_o, 1'b0);
    wait_done("t4b");
    chk("t4b_err", err_o, 1'b0);
    chk("t4b_rbeats", rbeat_glob, 4);

    // T5: abort during a write burst, ignored start while busy, zero-length start
    rx_avail = 64;
    start_xfer(1'b0, 1'b1, 32'h4000, 32'd64, 4);
    n = 0;
    while (!axi.m_wvalid && n < 200) begin @(negedge clk); n++; end
    chk("t5_reached_w", axi.m_wvalid, 1'b1);
    abort_i = 1'b1; start_i = 1'b1; dir_i = 1'b1; len_i = 32'd16;
    @(negedge clk);
    abort_i = 1'b0; start_i = 1'b0;
    wait_done("t5");
    chk("t5_bursts", bursts_seen, 1);
    chk("t5_beats_done", beats_done_o, 32'd4);
    chk("t5_err", err_o, 1'b0);
    start_xfer(1'b0, 1'b1, 32'h5000, 32'd0, 4);
    chk("t5_len0_done_now", done_o, 1'b1);
    wait_done("t5_len0");
    chk("t5_len0_no_axi", bursts_seen, 0);
    chk("t5_len0_beats", beats_done_o, 32'd0);

    // FIXED addressing read
    start_xfer(1'b1, 1'b0, 32'h0200, 32'd32, 16);
    wait_done("fixed");
    chk("fixed_bursts", bursts_seen, 1);
    if (obs_len.size() > 0) chk("fixed_arlen", obs_len[0], 8);
    chk("fixed_rbeats", rbeat_glob, 8);

    // T6: reset in the middle of a read burst
    start_xfer(1'b1, 1'b1, 32'h6000, 32'd64, 4);
    n = 0;
    while (!(rbeat_glob >= 2 && axi.m_rready) && n < 500) begin @(negedge clk); n++; end
    chk("t6_reached_r", axi.m_rready, 1'b1);
    rst_n = 1'b0;
    #1 check_reset_outs("t6_reset_mid_r");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_avail = 16;
    start_xfer(1'b0, 1'b1, 32'h7000, 32'd16, 16);
    wait_done("t6b");
    chk("t6b_bursts", bursts_seen, 1);
    if (obs_len.size() > 0) chk("t6b_awlen", obs_len[0], 4);
    chk("t6b_beats_done", beats_done_o, 32'd4);
    chk("t6b_err", err_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
